// File: rtl/posit_encode_8.sv
// Three-stage posit packer: (sign, scale, 1.frac) -> round-to-nearest-even N-bit posit
// with NaR/zero flags. One result per clock, done is start delayed by three cycles.
module posit_encode_8 #(
    parameter int N  = 8,
    parameter int es = 4,
    parameter int Bs = 3,
    parameter int SW = es + Bs + 2,
    parameter int FW = 8
) (
    input  logic          aclk,
    input  logic          reset,
    input  logic          start,
    input  logic          sign,
    input  logic [SW-1:0] scale,
    input  logic [FW-1:0] frac,
    input  logic          inf_in,
    input  logic          zero_in,
    output logic [N-1:0]  result,
    output logic          inf,
    output logic          zero,
    output logic          done
);
    localparam int STAGES = 3;
    localparam int KW     = Bs + 2;
    localparam int VW     = 2*N + FW;
    localparam int BW     = N - 1;
    localparam int PADW   = VW - 1 - es - FW;
    localparam logic signed [SW-1:0] SAT_HI = SW'((N-2) << es);
    localparam logic signed [SW-1:0] SAT_LO = -SAT_HI;

    typedef struct packed {
        logic          sign;
        logic          inf;
        logic          zero;
        logic          sat_hi;
        logic [KW-1:0] k;
        logic [es-1:0] e;
        logic [FW-1:0] frac;
    } s1_t;

    typedef struct packed {
        logic          sign;
        logic          inf;
        logic          zero;
        logic          sat_hi;
        logic [BW-1:0] body;
        logic          guard;
        logic          sticky;
    } s2_t;

    s1_t               s1_d, s1_q;
    s2_t               s2_d, s2_q;
    logic [STAGES:1]   vld_pipe;

    // Stage 1: clamp scale to the representable regime range, split into k and e.
    logic signed [SW-1:0] scale_s, scale_c;

    always_comb begin
        scale_s = $signed(scale);
        scale_c = scale_s;
        if (scale_s > SAT_HI)
            scale_c = SAT_HI;
        else if (scale_s < SAT_LO)
            scale_c = SAT_LO;
        s1_d.sign   = sign;
        s1_d.inf    = inf_in;
        s1_d.zero   = zero_in;
        s1_d.sat_hi = (scale_s >= SAT_HI);
        s1_d.k      = scale_c[SW-1:es];
        s1_d.e      = scale_c[es-1:0];
        s1_d.frac   = frac;
    end

    // Stage 2: the terminator bit sits at the top and is pushed right by the run
    // length; the vacated positions are filled with the regime run value.
    logic          pos;
    logic [KW-1:0] run;
    logic [VW-1:0] vec, fill, shv;

    always_comb begin
        pos  = ~s1_q.k[KW-1];
        run  = pos ? s1_q.k + KW'(1) : -s1_q.k;
        vec  = {~pos, s1_q.e, s1_q.frac, {PADW{1'b0}}};
        fill = pos ? ~({VW{1'b1}} >> run) : '0;
        shv  = (vec >> run) | fill;
        s2_d.sign   = s1_q.sign;
        s2_d.inf    = s1_q.inf;
        s2_d.zero   = s1_q.zero;
        s2_d.sat_hi = s1_q.sat_hi;
        s2_d.body   = shv[VW-1 -: BW];
        s2_d.guard  = shv[VW-1-BW];
        s2_d.sticky = |shv[VW-2-BW:0];
    end

    // Stage 3: RNE, then pin to maxpos/minpos so a finite value never becomes NaR or zero.
    logic          rnd;
    logic [N-1:0]  sum, mag, enc;
    logic [BW-1:0] body_f;

    always_comb begin
        rnd    = s2_q.guard & (s2_q.sticky | s2_q.body[0]);
        sum    = {1'b0, s2_q.body} + N'(rnd);
        body_f = sum[BW-1:0];
        if (sum[N-1] || s2_q.sat_hi)
            body_f = '1;
        else if (body_f == '0)
            body_f = BW'(1);
        mag = {1'b0, body_f};
        enc = s2_q.sign ? -mag : mag;
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            vld_pipe <= '0;
            result   <= '0;
            inf      <= 1'b0;
            zero     <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            vld_pipe <= {vld_pipe[STAGES-1:1], start};
            if (s2_q.inf) begin
                result <= {1'b1, {(N-1){1'b0}}};
                inf    <= 1'b1;
                zero   <= 1'b0;
            end else if (s2_q.zero) begin
                result <= '0;
                inf    <= 1'b0;
                zero   <= 1'b1;
            end else begin
                result <= enc;
                inf    <= 1'b0;
                zero   <= 1'b0;
            end
        end
    end

    assign done = vld_pipe[STAGES];

endmodule

// File: tb/tb_posit_encode_8.sv
// Scoreboard bench for posit_encode_8: stimulus pushes expected results tagged with
// their due cycle; a negedge monitor pops and compares on every done.
module tb_posit_encode_8;
    logic       aclk = 1'b0;
    logic       reset, start, sign, inf_in, zero_in;
    logic [8:0] scale;
    logic [7:0] frac;
    logic [7:0] result;
    logic       inf, zero, done;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] res;
        logic       inf;
        logic       zero;
        int         due;
    } exp_t;

    exp_t sb[$];

    posit_encode_8 dut (
        .aclk(aclk), .reset(reset), .start(start), .sign(sign), .scale(scale),
        .frac(frac), .inf_in(inf_in), .zero_in(zero_in),
        .result(result), .inf(inf), .zero(zero), .done(done)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Reference: lay the posit bit string down bit by bit, then round on guard/sticky.
    function automatic logic [9:0] ref_enc(input logic sg, input logic [8:0] sc,
                                           input logic [7:0] fr, input logic fi, input logic fz);
        int s, k, e, body, b;
        bit q[$];
        bit guard, sticky;
        if (fi) return {2'b10, 8'h80};
        if (fz) return {2'b01, 8'h00};
        s = int'($signed(sc));
        if (s > 96)  s = 96;
        if (s < -96) s = -96;
        k = (s >= 0) ? s / 16 : -((15 - s) / 16);
        e = s - 16 * k;
        if (k >= 0) begin
            repeat (k + 1) q.push_back(1'b1);
            q.push_back(1'b0);
        end else begin
            repeat (-k) q.push_back(1'b0);
            q.push_back(1'b1);
        end
        for (int i = 3; i >= 0; i--) q.push_back(e[i]);
        for (int i = 7; i >= 0; i--) q.push_back(fr[i]);
        body = 0;
        for (int i = 0; i < 7; i++) body = body * 2 + int'(q[i]);
        guard  = q[7];
        sticky = 1'b0;
        for (int i = 8; i < q.size(); i++) sticky = sticky | q[i];
        b = body + ((guard && (sticky || body[0])) ? 1 : 0);
        if (b > 127 || s == 96) b = 127;
        if (b == 0) b = 1;
        return {2'b00, sg ? 8'(256 - b) : 8'(b)};
    endfunction

    task automatic drive(input logic st, input logic sg, input logic [8:0] sc,
                         input logic [7:0] fr, input logic fi, input logic fz);
        @(posedge aclk);
        #1;
        start = st; sign = sg; scale = sc; frac = fr; inf_in = fi; zero_in = fz;
    endtask

    task automatic idle();
        drive(1'b0, 1'($urandom_range(0, 1)), 9'($urandom), 8'($urandom), 1'b0, 1'b0);
    endtask

    task automatic issue_k(input logic sg, input logic [8:0] sc, input logic [7:0] fr,
                           input logic fi, input logic fz,
                           input logic [7:0] er, input logic ei, input logic ez);
        drive(1'b1, sg, sc, fr, fi, fz);
        sb.push_back('{er, ei, ez, cyc + 3});
    endtask

    task automatic issue_r(input logic sg, input logic [8:0] sc, input logic [7:0] fr,
                           input logic fi, input logic fz);
        logic [9:0] x;
        drive(1'b1, sg, sc, fr, fi, fz);
        x = ref_enc(sg, sc, fr, fi, fz);
        sb.push_back('{x[7:0], x[9], x[8], cyc + 3});
    endtask

    task automatic issue_rand();
        logic [8:0] sc;
        sc = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 200) - 100);
        issue_r(1'($urandom_range(0, 1)), sc, 8'($urandom),
                $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
    endtask

    always @(negedge aclk) begin
        exp_t x;
        if (done) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL spurious_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                x = sb.pop_front();
                chk("result", int'(result), int'(x.res));
                chk("inf", int'(inf), int'(x.inf));
                chk("zero", int'(zero), int'(x.zero));
                chk("done_cycle", cyc, x.due);
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; sign = 1'b0; scale = '0; frac = '0;
        inf_in = 1'b0; zero_in = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("reset_result", int'(result), 0);
        chk("reset_flags", int'({inf, zero, done}), 0);
        @(posedge aclk);
        #1 reset = 1'b0;

        // Directed encodings with hand-derived expectations
        issue_k(0, 9'd0,        8'h00, 0, 0, 8'h40, 0, 0);
        issue_k(1, 9'd0,        8'h00, 0, 0, 8'hC0, 0, 0);
        issue_k(0, 9'd16,       8'h00, 0, 0, 8'h60, 0, 0);
        issue_k(0, 9'h1FF,      8'h00, 0, 0, 8'h3E, 0, 0);
        issue_k(0, 9'd0,        8'h80, 0, 0, 8'h41, 0, 0);
        issue_k(0, 9'd0,        8'h40, 0, 0, 8'h40, 0, 0);
        issue_k(0, 9'd0,        8'hC0, 0, 0, 8'h42, 0, 0);
        issue_k(0, 9'd0,        8'h41, 0, 0, 8'h41, 0, 0);
        issue_k(0, 9'd200,      8'hFF, 0, 0, 8'h7F, 0, 0);
        issue_k(0, 9'd96,       8'h00, 0, 0, 8'h7F, 0, 0);
        issue_k(1, 9'd96,       8'h00, 0, 0, 8'h81, 0, 0);
        issue_k(0, 9'(-200),    8'h00, 0, 0, 8'h01, 0, 0);
        issue_k(1, 9'(-200),    8'hFF, 0, 0, 8'hFF, 0, 0);
        issue_k(0, 9'(-96),     8'h00, 0, 0, 8'h01, 0, 0);
        issue_k(0, 9'd95,       8'h00, 0, 0, 8'h7F, 0, 0);
        issue_k(0, 9'd5,        8'h33, 1, 1, 8'h80, 1, 0);
        issue_k(1, 9'd5,        8'h33, 0, 1, 8'h00, 0, 1);
        repeat (5) idle();

        // Two starts in flight, then reset: neither may produce done
        issue_k(0, 9'd3, 8'h10, 0, 0, 8'h00, 0, 0);
        issue_k(1, 9'd7, 8'h20, 0, 0, 8'h00, 0, 0);
        @(posedge aclk);
        #1;
        reset = 1'b1;
        start = 1'b0;
        sb.delete();
        #1;
        chk("midreset_result", int'(result), 0);
        chk("midreset_flags", int'({inf, zero, done}), 0);
        repeat (4) begin
            @(posedge aclk);
            #1 chk("reset_done_low", int'(done), 0);
        end
        reset = 1'b0;
        issue_k(0, 9'd16, 8'h00, 0, 0, 8'h60, 0, 0);
        repeat (4) idle();

        // Back-to-back random stream, then a stream with gaps
        repeat (300) issue_rand();
        repeat (100) begin
            if ($urandom_range(0, 2) == 0) idle();
            else issue_rand();
        end
        repeat (8) idle();
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
